// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port instruction/data RAM between the
// core's fetch port and its load/store port. One access is outstanding at a
// time; the next one may issue in the completion cycle of the previous one.
// Data wins contention unless fetch has been denied STARVE_MAX cycles in a row.
// Optional build macro ARB_PERF_CNT_EN adds saturating per-port stall counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no access outstanding, lat_cnt == 0, issue slot open
// ST_BUSY  | access outstanding, lat_cnt counts down to the completion
//          | cycle (lat_cnt == 1), where the slot reopens
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]     if_stall_cnt,
  output logic [31:0]     d_stall_cnt
`endif
);

  localparam logic [3:0] LAT_C    = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t     state_q, state_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  logic [3:0] starve_q, starve_d;
  logic       owner_q, owner_d;   // 0 = fetch, 1 = data
  logic       store_q, store_d;   // outstanding data access is a store
  logic       slot_open;
  logic       complete;

  // Everything visible is forced quiet while reset is asserted, so a
  // transaction abandoned by reset can never complete.
  assign slot_open = !rstn && (lat_cnt_q <= 4'd1);
  assign complete  = !rstn && (lat_cnt_q == 4'd1);
  assign busy      = !rstn && (state_q == ST_BUSY);

  // State register, latency down-counter, owner and starvation counter.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= 4'd0;
      starve_q  <= 4'd0;
      owner_q   <= 1'b0;
      store_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      starve_q  <= starve_d;
      owner_q   <= owner_d;
      store_q   <= store_d;
    end
  end

  // Arbitration, RAM port mux and next-state logic.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    owner_d   = owner_q;
    store_d   = store_q;
    starve_d  = starve_q;

    if (slot_open) begin
      if (d_req && (!if_req || (starve_q < STARVE_C))) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end

    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_be    = '1;
      mem_addr  = if_addr;
    end

    if (d_gnt || if_gnt) begin
      state_d   = ST_BUSY;
      lat_cnt_d = LAT_C;
      owner_d   = d_gnt;
      store_d   = d_gnt && d_we;
    end else if (lat_cnt_q != 4'd0) begin
      lat_cnt_d = lat_cnt_q - 4'd1;
      state_d   = (lat_cnt_q == 4'd1) ? ST_IDLE : ST_BUSY;
    end

    if (if_req && !if_gnt) begin
      starve_d = (starve_q >= STARVE_C) ? STARVE_C : starve_q + 4'd1;
    end else begin
      starve_d = 4'd0;
    end
  end

  // Completion-cycle response routing; a store acks with zero data.
  always_comb begin
    if_rvalid = complete && !owner_q;
    d_rvalid  = complete && owner_q;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !store_q) ? mem_rdata : '0;
  end

`ifdef ARB_PERF_CNT_EN
  // Saturating counts of cycles each requester waited without a grant.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if_stall_cnt <= 32'd0;
      d_stall_cnt  <= 32'd0;
    end else begin
      if (if_req && !if_gnt && (if_stall_cnt != 32'hFFFF_FFFF))
        if_stall_cnt <= if_stall_cnt + 32'd1;
      if (d_req && !d_gnt && (d_stall_cnt != 32'hFFFF_FFFF))
        d_stall_cnt <= d_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance a (MEM_LAT=1) and instance b
// (MEM_LAT=3), each with a small RAM model. Stimulus pushes expected responses
// into a per-instance queue; monitors pop and compare on every rvalid.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // ---------------- instance a signals ----------------
  logic        a_rstn, a_if_req, a_d_req, a_d_we;
  logic [31:0] a_if_addr, a_d_addr, a_d_wdata, a_mem_rdata;
  logic [3:0]  a_d_be;
  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [3:0]  a_mem_be;
  // ---------------- instance b signals ----------------
  logic        b_rstn, b_if_req, b_d_req, b_d_we;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata, b_mem_rdata;
  logic [3:0]  b_d_be;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [3:0]  b_mem_be;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] a_if_stall_cnt, a_d_stall_cnt, b_if_stall_cnt, b_d_stall_cnt;
`endif

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rstn(a_rstn),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr),
    .d_wdata(a_d_wdata), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
`ifdef ARB_PERF_CNT_EN
    , .if_stall_cnt(a_if_stall_cnt), .d_stall_cnt(a_d_stall_cnt)
`endif
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rstn(b_rstn),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
`ifdef ARB_PERF_CNT_EN
    , .if_stall_cnt(b_if_stall_cnt), .d_stall_cnt(b_d_stall_cnt)
`endif
  );

  // ---------------- RAM models ----------------
  // Unwritten words read as 0x1000_0000 | addr, except 0x10 which holds 0x13.
  function automatic logic [31:0] dflt(input logic [31:0] addr);
    return (addr == 32'h10) ? 32'h13 : (32'h1000_0000 | addr);
  endfunction

  logic [31:0] ram_a [0:255];
  bit          wr_a  [0:255];
  logic [31:0] ram_b [0:255];
  bit          wr_b  [0:255];
  logic [31:0] pa;
  logic [31:0] pb [0:2];

  function automatic logic [31:0] rd_a(input logic [31:0] addr);
    return wr_a[addr[9:2]] ? ram_a[addr[9:2]] : dflt({addr[31:2], 2'b00});
  endfunction
  function automatic logic [31:0] rd_b(input logic [31:0] addr);
    return wr_b[addr[9:2]] ? ram_b[addr[9:2]] : dflt({addr[31:2], 2'b00});
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) begin
      ram_a[a_mem_addr[9:2]] <= merge(rd_a(a_mem_addr), a_mem_wdata, a_mem_be);
      wr_a[a_mem_addr[9:2]]  <= 1'b1;
    end
    pa <= rd_a(a_mem_addr);
  end
  assign a_mem_rdata = pa;

  always @(posedge clk) begin
    if (b_mem_en && b_mem_we) begin
      ram_b[b_mem_addr[9:2]] <= merge(rd_b(b_mem_addr), b_mem_wdata, b_mem_be);
      wr_b[b_mem_addr[9:2]]  <= 1'b1;
    end
    pb[0] <= rd_b(b_mem_addr);
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign b_mem_rdata = pb[2];

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Instance a response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (a_if_rvalid || a_d_rvalid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rvalid", {a_if_rvalid, a_d_rvalid}, 64'd0);
      end else begin
        e = qa.pop_front();
        chk("a_rsp_port", {a_if_rvalid, a_d_rvalid}, e.is_data ? 2'b01 : 2'b10);
        chk("a_rsp_data", e.is_data ? a_d_rdata : a_if_rdata, e.data);
        chk("a_rsp_other", e.is_data ? a_if_rdata : a_d_rdata, 32'd0);
        chk("a_rsp_cycle", cyc, e.cyc);
      end
    end else if (qa.size() != 0 && qa[0].cyc <= cyc) begin
      e = qa.pop_front();
      chk("a_missing_rvalid", 64'd0, 64'd1);
    end
  end

  // Instance b response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (b_if_rvalid || b_d_rvalid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rvalid", {b_if_rvalid, b_d_rvalid}, 64'd0);
      end else begin
        e = qb.pop_front();
        chk("b_rsp_port", {b_if_rvalid, b_d_rvalid}, e.is_data ? 2'b01 : 2'b10);
        chk("b_rsp_data", e.is_data ? b_d_rdata : b_if_rdata, e.data);
        chk("b_rsp_other", e.is_data ? b_if_rdata : b_d_rdata, 32'd0);
        chk("b_rsp_cycle", cyc, e.cyc);
      end
    end else if (qb.size() != 0 && qb[0].cyc <= cyc) begin
      e = qb.pop_front();
      chk("b_missing_rvalid", 64'd0, 64'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input bit is_data, input logic [31:0] data, input int lat);
    exp_t e;
    e.is_data = is_data; e.data = data; e.cyc = cyc + lat;
    qa.push_back(e);
  endtask

  task automatic push_b(input bit is_data, input logic [31:0] data, input int lat);
    exp_t e;
    e.is_data = is_data; e.data = data; e.cyc = cyc + lat;
    qb.push_back(e);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_a"}, {a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid, a_mem_en, a_mem_we, a_busy,
                     a_mem_be, a_mem_addr, a_if_rdata != 0, a_d_rdata != 0}, 64'd0);
    chk({nm, "_b"}, {b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid, b_mem_en, b_mem_we, b_busy,
                     b_mem_be, b_mem_addr, b_if_rdata != 0, b_d_rdata != 0}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    a_rstn = 1; a_if_req = 1; a_if_addr = 32'h10; a_d_req = 1; a_d_we = 1;
    a_d_be = 4'hF; a_d_addr = 32'h10; a_d_wdata = 32'h55;
    b_rstn = 1; b_if_req = 1; b_if_addr = 32'h10; b_d_req = 1; b_d_we = 1;
    b_d_be = 4'hF; b_d_addr = 32'h10; b_d_wdata = 32'h55;

    // Reset held with both requests asserted.
    repeat (2) begin
      tick();
      @(negedge clk);
      chk_quiet("reset_quiet");
    end
    tick();
    a_rstn = 0; a_if_req = 0; a_d_req = 0; a_d_we = 0; a_d_be = 0;
    b_rstn = 0; b_if_req = 0; b_d_req = 0; b_d_we = 0; b_d_be = 0;
    @(negedge clk);
    chk_quiet("post_reset_quiet");
    tick();
    @(negedge clk);
    chk_quiet("post_reset_quiet2");

    // Single fetch, MEM_LAT=1.
    tick();
    a_if_req = 1; a_if_addr = 32'h10;
    @(negedge clk);
    chk("fetch_gnt", {a_if_gnt, a_d_gnt, a_mem_en, a_mem_we}, 4'b1010);
    chk("fetch_mem_be_addr", {a_mem_be, a_mem_addr}, {4'hF, 32'h10});
    push_a(1'b0, 32'h13, 1);
    tick();
    a_if_req = 0;
    @(negedge clk);
    chk("fetch_busy", {a_busy, a_if_gnt, a_mem_en}, 3'b100);
    tick();
    @(negedge clk);
    chk("fetch_idle", a_busy, 1'b0);

    // Contention, both held for 10 cycles: data x4, fetch x1, repeat.
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) begin
        a_if_req = 1; a_if_addr = 32'h80;
        a_d_req = 1; a_d_we = 0; a_d_be = 4'hF; a_d_addr = 32'h40;
      end
      @(negedge clk);
      if (k % 5 == 4) begin
        chk("contend_gnt", {a_if_gnt, a_d_gnt, a_mem_addr}, {2'b10, 32'h80});
        push_a(1'b0, 32'h1000_0080, 1);
      end else begin
        chk("contend_gnt", {a_if_gnt, a_d_gnt, a_mem_addr}, {2'b01, 32'h40});
        push_a(1'b1, 32'h1000_0040, 1);
      end
    end
    tick();
    a_if_req = 0; a_d_req = 0; a_d_be = 0;
    @(negedge clk);
    chk("contend_tail_busy", a_busy, 1'b1);
`ifdef ARB_PERF_CNT_EN
    chk("perf_if_stall", a_if_stall_cnt, 32'd8);
    chk("perf_d_stall", a_d_stall_cnt, 32'd2);
`endif
    tick();
    @(negedge clk);

    // MEM_LAT=3: store at cycle 0, fetch requested from cycle 1.
    tick();
    b_d_req = 1; b_d_we = 1; b_d_be = 4'hF; b_d_addr = 32'h20; b_d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("st_gnt", {b_d_gnt, b_if_gnt, b_mem_en, b_mem_we}, 4'b1011);
    chk("st_mem", {b_mem_be, b_mem_addr, b_mem_wdata}, {4'hF, 32'h20, 32'hDEAD_BEEF});
    push_b(1'b1, 32'h0, 3);
    tick();
    b_d_req = 0; b_d_we = 0; b_d_be = 0; b_d_wdata = 0;
    b_if_req = 1; b_if_addr = 32'h20;
    @(negedge clk);
    chk("st_wait1", {b_if_gnt, b_d_gnt, b_mem_en, b_mem_we, b_busy}, 5'b00001);
    tick();
    @(negedge clk);
    chk("st_wait2", {b_if_gnt, b_d_gnt, b_mem_en, b_mem_we, b_busy}, 5'b00001);
    tick();
    @(negedge clk);
    chk("st_b2b_fetch", {b_if_gnt, b_mem_en, b_mem_we, b_mem_addr}, {3'b110, 32'h20});
    push_b(1'b0, 32'hDEAD_BEEF, 3);
    tick();
    b_if_req = 0;
    @(negedge clk);
    chk("st_wait4", {b_mem_en, b_mem_we, b_busy}, 3'b001);
    tick();
    @(negedge clk);
    chk("st_wait5", {b_mem_en, b_mem_we, b_busy}, 3'b001);
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("st_done_idle", b_busy, 1'b0);

    // MEM_LAT=3: reset one cycle after a load grant abandons it.
    tick();
    b_d_req = 1; b_d_we = 0; b_d_addr = 32'h44;
    @(negedge clk);
    chk("rst_mid_gnt", {b_d_gnt, b_mem_en}, 2'b11);
    tick();
    b_d_req = 0; b_rstn = 1;
    @(negedge clk);
    chk("rst_mid_busy1", {b_busy, b_d_gnt, b_mem_en}, 3'b000);
    tick();
    b_rstn = 0;
    @(negedge clk);
    chk("rst_mid_busy2", b_busy, 1'b0);
    tick();
    @(negedge clk);
    chk("rst_mid_no_rvalid", {b_d_rvalid, b_if_rvalid, b_busy}, 3'b000);
    tick();
    @(negedge clk);

    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data RAM between the core's fetch port and its load/store port.
- Sits between the xgriscv core and the RAM. Sequences one outstanding access at a time with a fixed read latency.
- Data access has priority. An anti-starvation counter guarantees fetch progress.
- Grant and completion are signalled per requester so the core can stall.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byte-enable width is DW/8).
- MEM_LAT, 1, RAM latency in cycles from the enable cycle to the rdata-valid cycle; legal range 1..8.
- STARVE_MAX, 4, consecutive denied fetch-request cycles after which fetch wins; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  AW  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DW  fetch data.
- d_req  in  1  data request; held with its fields until d_gnt.
- d_we  in  1  1 = store.
- d_be  in  DW/8  store byte enables.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  load data valid, or store completion.
- d_rdata  out  DW  load data.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write.
- mem_be  out  DW/8  RAM byte enables.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  a transaction is outstanding.

Behaviour:
- Reset (rstn=1 at clk edge):
  - state cleared to IDLE; lat_cnt=0; owner=0; starve_cnt=0.
  - While rstn=1: all gnt, rvalid, mem_en, mem_we and busy are 0; all data/address outputs are 0.
  - Reset mid-transaction abandons it; no rvalid is ever produced for it.
- Internal state:
  - lat_cnt (4 bit) and owner (0 = fetch, 1 = data).
  - busy = (lat_cnt != 0).
  - Completion cycle: lat_cnt == 1.
- Issue slot: open when lat_cnt == 0 or lat_cnt == 1. Back-to-back issue is allowed in the completion cycle. MEM_LAT=1 gives one access per cycle.
- Arbitration (combinational, Mealy, within an open slot):
  - Only d_req: d_gnt=1.
  - Only if_req: if_gnt=1.
  - Both, and starve_cnt < STARVE_MAX: d_gnt=1.
  - Both, and starve_cnt == STARVE_MAX: if_gnt=1.
  - Slot closed: both gnt=0.
  - At most one gnt per cycle.
- mem_* outputs:
  - Granted cycle: driven combinationally from the granted requester. Fetch drives mem_we=0 and mem_be=all ones.
  - Otherwise: mem_en=0 and mem_we/be/addr/wdata=0.
- On grant: lat_cnt <= MEM_LAT and owner <= granted requester. Otherwise, when lat_cnt != 0, lat_cnt decrements.
- Response, in the completion cycle:
  - The owner's rvalid=1 and its rdata=mem_rdata (combinational pass-through).
  - A store also pulses d_rvalid as its ack; d_rdata is then 0.
  - The non-owner's rvalid=0 and rdata=0.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each cycle with if_req=1 and if_gnt=0.
  - Clears on if_gnt or on if_req=0.
- Latency: grant at cycle t gives rvalid at cycle t+MEM_LAT.
- Deasserting a req before its gnt is a protocol error with no side effect: simply no grant.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds output ports if_stall_cnt[31:0] and d_stall_cnt[31:0].
  - Each increments on every cycle where its req=1 and gnt=0.
  - Each saturates at 0xFFFFFFFF and clears on reset.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Reset: rstn=1 for 2 cycles with if_req=d_req=1 -> all gnt, rvalid, mem_en and busy stay 0. No rvalid after rstn falls without a new grant.
- Single fetch, MEM_LAT=1: if_req, if_addr=0x10, mem_rdata=0x00000013 -> if_gnt and mem_en, mem_addr=0x10 in cycle 0; if_rvalid=1, if_rdata=0x13 in cycle 1.
- Contention, MEM_LAT=1, STARVE_MAX=4, both req held -> d_gnt cycles 0-3, if_gnt cycle 4. The pattern then repeats; fetch is never starved more than 4 cycles.
- MEM_LAT=3: store to 0x20 (d_be=0xF, d_wdata=0xDEADBEEF) at cycle 0, if_req from cycle 1 -> if_gnt and d_rvalid both at cycle 3; if_rvalid at cycle 6; mem_we=1 only at cycle 0.
- Reset mid-op, MEM_LAT=3: load granted cycle 0, rstn=1 at cycle 1 -> no d_rvalid at cycle 3; busy=0 from cycle 2.
- With ARB_PERF_CNT_EN, using the contention scenario for 10 cycles -> if_stall_cnt=8, d_stall_cnt=2.
